// File: rtl/cpu_bus_pkg.sv
// Shared types and beat-count helpers for the CPU bus serializer.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_DONE
  } bus_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Beats per address phase: long enough for whichever of address/data is wider.
  function automatic int beat_count(input int addr_w, input int data_w, input int pin_w);
    int a_beats;
    int d_beats;
    a_beats = ceil_div(addr_w, pin_w);
    d_beats = ceil_div(data_w, pin_w);
    return (a_beats > d_beats) ? a_beats : d_beats;
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_bus_serializer_if.sv
// CPU-side request/response handshake of the serializer.
interface cpu_bus_serializer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );

endinterface

// File: rtl/bus_beat_counter.sv
// Up-counter with synchronous clear and a runtime terminal-count compare.
module bus_beat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  // Clear wins over enable; wraps silently, callers leave the state before that matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + 1'b1;
  end

  assign tc = (count == term);

endmodule

// File: rtl/cpu_bus_serializer.sv
// Serializes a parallel CPU request onto PIN_W-wide external pins, with
// wait states from the target, read-back and a timeout error.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | req_ready high, waiting for a request handshake
//   ST_ADDR  | NBEATS address/write-data beats, LSB slice first
//   ST_WAIT  | waiting for ext_ready, timeout after WAIT_MAX cycles
//   ST_RDATA | DBEATS read beats captured from pin_data_in
//   ST_DONE  | one-cycle resp_valid pulse, frame released
module cpu_bus_serializer
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PIN_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_bus_serializer_if.slave  bus,
  output logic [PIN_W-1:0]     pin_addr,
  output logic [PIN_W-1:0]     pin_data_out,
  input  logic [PIN_W-1:0]     pin_data_in,
  output logic [PIN_W-1:0]     pin_data_oe,
  output logic                 pin_frame,
  output logic                 pin_sync,
  output logic                 pin_rw,
  input  logic                 ext_ready
);

  localparam int DBEATS = ceil_div(DATA_W, PIN_W);
  localparam int NBEATS = beat_count(ADDR_W, DATA_W, PIN_W);
  localparam int SH_W   = NBEATS * PIN_W;
  localparam int RD_W   = DBEATS * PIN_W;
  localparam int BC_W   = cnt_width(NBEATS);
  localparam int WC_W   = cnt_width(WAIT_MAX);
  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(NBEATS - 1);
  localparam logic [BC_W-1:0] RD_LAST   = BC_W'(DBEATS - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

  bus_state_e        state;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [SH_W-1:0]   addr_sh;
  logic [SH_W-1:0]   wdata_sh;
  logic [RD_W-1:0]   rd_sh;
  logic [SH_W-1:0]   req_addr_pad;
  logic [SH_W-1:0]   req_wdata_pad;
  logic [RD_W-1:0]   rd_next;
  logic              beat_clr, beat_en, beat_tc;
  logic [BC_W-1:0]   beat_term;
  logic              wait_clr, wait_en, wait_tc;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  assign req_addr_pad  = SH_W'(bus.req_addr);
  assign req_wdata_pad = SH_W'(bus.req_wdata);
  // New beat enters at the top so the first beat ends up in the LSB slice.
  assign rd_next       = RD_W'({pin_data_in, rd_sh} >> PIN_W);

  // Counter controls: beat index runs in ADDR and RDATA, wait count only in WAIT.
  always_comb begin
    beat_clr  = (state != ST_ADDR) && (state != ST_RDATA);
    beat_en   = !beat_clr;
    beat_term = (state == ST_RDATA) ? RD_LAST : ADDR_LAST;
    wait_clr  = (state != ST_WAIT);
    wait_en   = (state == ST_WAIT) && !ext_ready;
  end

  bus_beat_counter #(.W(BC_W)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat_clr),
    .en    (beat_en),
    .term  (beat_term),
    .tc    (beat_tc)
  );

  bus_beat_counter #(.W(WC_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .term  (WAIT_LAST),
    .tc    (wait_tc)
  );

  // Transaction FSM; every pin and response output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_sh      <= '0;
      wdata_sh     <= '0;
      rd_sh        <= '0;
      pin_addr     <= '0;
      pin_data_out <= '0;
      pin_data_oe  <= '0;
      pin_frame    <= 1'b0;
      pin_sync     <= 1'b0;
      pin_rw       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && bus.req_valid) begin
            ready_q   <= 1'b0;
            state     <= ST_ADDR;
            pin_addr  <= req_addr_pad[PIN_W-1:0];
            addr_sh   <= req_addr_pad >> PIN_W;
            pin_frame <= 1'b1;
            pin_sync  <= 1'b1;
            pin_rw    <= bus.req_write;
            if (bus.req_write) begin
              pin_data_out <= req_wdata_pad[PIN_W-1:0];
              wdata_sh     <= req_wdata_pad >> PIN_W;
              pin_data_oe  <= '1;
            end else begin
              pin_data_out <= '0;
              wdata_sh     <= '0;
              pin_data_oe  <= '0;
            end
          end
        end
        ST_ADDR: begin
          pin_sync <= 1'b0;
          if (beat_tc) begin
            state        <= ST_WAIT;
            pin_addr     <= '0;
            pin_data_out <= '0;
            pin_data_oe  <= '0;
          end else begin
            pin_addr     <= addr_sh[PIN_W-1:0];
            addr_sh      <= addr_sh >> PIN_W;
            pin_data_out <= wdata_sh[PIN_W-1:0];
            wdata_sh     <= wdata_sh >> PIN_W;
          end
        end
        ST_WAIT: begin
          // ext_ready is checked first so it beats a coincident timeout.
          if (ext_ready) begin
            if (pin_rw) begin
              state        <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
              pin_frame    <= 1'b0;
              pin_rw       <= 1'b0;
            end else begin
              state <= ST_RDATA;
              rd_sh <= '0;
            end
          end else if (wait_tc) begin
            state        <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            pin_frame    <= 1'b0;
            pin_rw       <= 1'b0;
          end
        end
        ST_RDATA: begin
          rd_sh <= rd_next;
          if (beat_tc) begin
            state        <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= DATA_W'(rd_next);
            pin_frame    <= 1'b0;
            pin_rw       <= 1'b0;
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Scoreboard bench: drivers push expected beats/responses, monitors pop and compare.
module tb_cpu_bus_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;

  // ---------------- DUT A: default parameters ----------------
  cpu_bus_serializer_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  logic [7:0] a_pin_addr, a_pin_dout, a_pin_din, a_pin_oe;
  logic       a_frame, a_sync, a_rw, a_ext_ready;

  cpu_bus_serializer #(.ADDR_W(32), .DATA_W(32), .PIN_W(8), .WAIT_MAX(15)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_a),
    .pin_addr     (a_pin_addr),
    .pin_data_out (a_pin_dout),
    .pin_data_in  (a_pin_din),
    .pin_data_oe  (a_pin_oe),
    .pin_frame    (a_frame),
    .pin_sync     (a_sync),
    .pin_rw       (a_rw),
    .ext_ready    (a_ext_ready)
  );

  // ---------------- DUT B: narrow pins ----------------
  cpu_bus_serializer_if #(.ADDR_W(12), .DATA_W(16)) bus_b ();
  logic [3:0] b_pin_addr, b_pin_dout, b_pin_din, b_pin_oe;
  logic       b_frame, b_sync, b_rw, b_ext_ready;

  cpu_bus_serializer #(.ADDR_W(12), .DATA_W(16), .PIN_W(4), .WAIT_MAX(15)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_b),
    .pin_addr     (b_pin_addr),
    .pin_data_out (b_pin_dout),
    .pin_data_in  (b_pin_din),
    .pin_data_oe  (b_pin_oe),
    .pin_frame    (b_frame),
    .pin_sync     (b_sync),
    .pin_rw       (b_rw),
    .ext_ready    (b_ext_ready)
  );

  typedef struct { int cyc; logic [7:0] addr; logic [7:0] dout; logic [7:0] oe; logic rw; } beat_t;
  typedef struct { int cyc; logic err; logic [31:0] rdata; } resp_t;

  beat_t beat_qa[$];
  resp_t resp_qa[$];
  beat_t beat_qb[$];
  resp_t resp_qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Beat monitor A: a sync pulse starts a 4-beat address phase.
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (mon_en && a_sync === 1'b1) begin
      if (beat_qa.size() < 4) chk("a_unexpected_sync", a_sync, 0);
      else for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        b = beat_qa.pop_front();
        chk("a_beat_cycle", cyc, b.cyc);
        chk("a_pin_addr", a_pin_addr, b.addr);
        chk("a_pin_data_out", a_pin_dout, b.dout);
        chk("a_pin_data_oe", a_pin_oe, b.oe);
        chk("a_pin_frame", a_frame, 1);
        chk("a_pin_rw", a_rw, b.rw);
        chk("a_pin_sync", a_sync, (k == 0));
      end
    end
  end

  // Response monitor A.
  initial forever begin
    resp_t r;
    @(negedge clk);
    if (bus_a.resp_valid === 1'b1) begin
      if (resp_qa.size() == 0) chk("a_unexpected_resp", bus_a.resp_valid, 0);
      else begin
        r = resp_qa.pop_front();
        chk("a_resp_cycle", cyc, r.cyc);
        chk("a_resp_err", bus_a.resp_err, r.err);
        chk("a_resp_rdata", bus_a.resp_rdata, r.rdata);
        chk("a_done_frame", a_frame, 0);
        chk("a_done_oe", a_pin_oe, 0);
      end
    end
  end

  // Beat monitor B.
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (b_sync === 1'b1) begin
      if (beat_qb.size() < 4) chk("b_unexpected_sync", b_sync, 0);
      else for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        b = beat_qb.pop_front();
        chk("b_beat_cycle", cyc, b.cyc);
        chk("b_pin_addr", b_pin_addr, b.addr[3:0]);
        chk("b_pin_data_out", b_pin_dout, b.dout[3:0]);
        chk("b_pin_data_oe", b_pin_oe, b.oe[3:0]);
      end
    end
  end

  // Response monitor B.
  initial forever begin
    resp_t r;
    @(negedge clk);
    if (bus_b.resp_valid === 1'b1) begin
      if (resp_qb.size() == 0) chk("b_unexpected_resp", bus_b.resp_valid, 0);
      else begin
        r = resp_qb.pop_front();
        chk("b_resp_cycle", cyc, r.cyc);
        chk("b_resp_err", bus_b.resp_err, r.err);
        chk("b_resp_rdata", bus_b.resp_rdata, r.rdata[15:0]);
      end
    end
  end

  // One DUT A transaction. wl >= 15 means ext_ready never rises (timeout).
  task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int wl, input logic [31:0] rd_word, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_hs, input bit track,
                       output int hs);
    int n = 0;
    int rc;
    beat_t b;
    resp_t r;
    a_pin_din = 8'h5A;
    @(negedge clk);
    while (bus_a.req_ready !== 1'b1) begin
      n++;
      if (n > 50) begin
        chk("a_req_ready_timeout", bus_a.req_ready, 1);
        hs = cyc;
        return;
      end
      @(negedge clk);
    end
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    hs = cyc;
    if (exp_hs >= 0) chk("a_accept_cycle", hs, exp_hs);
    if (track) begin
      for (int k = 0; k < 4; k++) begin
        b.cyc  = hs + 1 + k;
        b.addr = addr[8*k +: 8];
        b.dout = wr ? wdata[8*k +: 8] : 8'h00;
        b.oe   = wr ? 8'hFF : 8'h00;
        b.rw   = wr;
        beat_qa.push_back(b);
      end
      if (wl >= 15) rc = hs + 20;
      else rc = wr ? (hs + 6 + wl) : (hs + 10 + wl);
      r.cyc = rc;
      r.err = exp_err;
      r.rdata = exp_rdata;
      resp_qa.push_back(r);
    end
    @(posedge clk);
    #1;
    bus_a.req_valid = 1'b0;
    bus_a.req_write = ~wr;
    bus_a.req_addr  = $urandom;
    bus_a.req_wdata = $urandom;
    if (!track) return;
    @(negedge clk);
    if (wl < 15) begin
      wait_cyc(hs + 5 + wl);
      a_ext_ready = 1'b1;
      @(negedge clk);
      a_ext_ready = 1'b0;
      if (!wr) for (int j = 0; j < 4; j++) begin
        wait_cyc(hs + 6 + wl + j);
        a_pin_din = rd_word[8*j +: 8];
      end
    end
    wait_cyc(rc);
  endtask

  // One DUT B transaction; ext_ready is held high for this DUT.
  task automatic txn_b(input logic wr, input logic [11:0] addr, input logic [15:0] wdata,
                       input logic [15:0] rd_word, input logic [15:0] exp_rdata);
    int n = 0;
    int hs;
    beat_t b;
    resp_t r;
    @(negedge clk);
    while (bus_b.req_ready !== 1'b1) begin
      n++;
      if (n > 50) begin
        chk("b_req_ready_timeout", bus_b.req_ready, 1);
        return;
      end
      @(negedge clk);
    end
    bus_b.req_valid = 1'b1;
    bus_b.req_write = wr;
    bus_b.req_addr  = addr;
    bus_b.req_wdata = wdata;
    hs = cyc;
    for (int k = 0; k < 4; k++) begin
      b.cyc  = hs + 1 + k;
      b.addr = (k < 3) ? {4'h0, addr[4*k +: 4]} : 8'h00;
      b.dout = wr ? {4'h0, wdata[4*k +: 4]} : 8'h00;
      b.oe   = wr ? 8'h0F : 8'h00;
      b.rw   = wr;
      beat_qb.push_back(b);
    end
    r.cyc = wr ? hs + 6 : hs + 10;
    r.err = 1'b0;
    r.rdata = {16'h0, exp_rdata};
    resp_qb.push_back(r);
    @(posedge clk);
    #1;
    bus_b.req_valid = 1'b0;
    bus_b.req_addr  = 12'hFFF;
    bus_b.req_wdata = 16'hFFFF;
    @(negedge clk);
    if (!wr) for (int j = 0; j < 4; j++) begin
      wait_cyc(hs + 6 + j);
      b_pin_din = rd_word[4*j +: 4];
    end
    wait_cyc(r.cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int hs_prev;
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    a_pin_din = 8'h00; a_ext_ready = 1'b0;
    b_pin_din = 4'h0;  b_ext_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_pin_frame", a_frame, 0);
    chk("rst_pin_oe", a_pin_oe, 0);
    chk("rst_resp_valid", bus_a.resp_valid, 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_req_ready", bus_a.req_ready, 1);

    // write, immediate ready
    txn_a(1'b1, 32'h12345678, 32'hCAFEF00D, 0, 32'h0, 1'b0, 32'h0, -1, 1'b1, hs);
    // read, immediate ready
    txn_a(1'b0, 32'h00000010, 32'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, -1, 1'b1, hs);
    // read, three wait cycles
    txn_a(1'b0, 32'h0000ABCD, 32'h0, 3, 32'h01234567, 1'b0, 32'h01234567, -1, 1'b1, hs);
    // write timeout, then a read accepted the cycle after the error response
    txn_a(1'b1, 32'h000055AA, 32'h00000001, 99, 32'h0, 1'b1, 32'h0, -1, 1'b1, hs_prev);
    txn_a(1'b0, 32'h00000004, 32'h0, 0, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, hs_prev + 21, 1'b1, hs);

    // reset during address beat 2
    mon_en = 1'b0;
    txn_a(1'b1, 32'h0BADF00D, 32'h11112222, 0, 32'h0, 1'b0, 32'h0, -1, 1'b0, hs);
    wait_cyc(hs + 3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_pin_addr", a_pin_addr, 0);
    chk("midrst_pin_data_out", a_pin_dout, 0);
    chk("midrst_pin_oe", a_pin_oe, 0);
    chk("midrst_pin_frame", a_frame, 0);
    chk("midrst_pin_rw", a_rw, 0);
    chk("midrst_req_ready", bus_a.req_ready, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_midrst_req_ready", bus_a.req_ready, 1);

    // ready arrives on the last possible wait cycle: no error
    txn_a(1'b1, 32'hFFFF0001, 32'h80000001, 14, 32'h0, 1'b0, 32'h0, -1, 1'b1, hs);
    // read timeout: error, rdata forced to zero
    txn_a(1'b0, 32'h00000020, 32'h0, 99, 32'h13572468, 1'b1, 32'h0, -1, 1'b1, hs);

    // narrow-pin instance
    txn_b(1'b1, 12'hABC, 16'h1234, 16'h0, 16'h0);
    txn_b(1'b0, 12'h123, 16'h0, 16'hBEEF, 16'hBEEF);

    repeat (3) @(negedge clk);
    chk("a_resp_drain", resp_qa.size(), 0);
    chk("a_beat_drain", beat_qa.size(), 0);
    chk("b_resp_drain", resp_qb.size(), 0);
    chk("b_beat_drain", beat_qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
